// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYC cycles).
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 12,
  parameter int NEWD_HOLD   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        spi_newd,
  output logic [DATA_W-1:0]           spi_din,
  input  logic                        spi_done,
  input  logic [DATA_W-1:0]           spi_dout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int HW = $clog2(NEWD_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   spi_din_q, spi_din_d;
  logic                spi_newd_q, spi_newd_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                done_q;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                rsp_err_q, rsp_err_d;

  logic                pick_valid;
  logic [GW-1:0]       pick_idx;
  logic [GW:0]         cand;
  logic                done_rise;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       wait_q, wait_d;
`endif

  assign done_rise = spi_done & ~done_q;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = grant_id_q;
    cand       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, grant_id_q} + (GW+1)'(i);
      if (cand >= (GW+1)'(NUM_REQ)) begin
        cand = cand - (GW+1)'(NUM_REQ);
      end
      if (!pick_valid && req[cand[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    spi_din_d  = spi_din_q;
    spi_newd_d = 1'b0;
    hold_d     = hold_q;
    rsp_data_d = rsp_data_q;
    ack_d      = '0;
    rsp_err_d  = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    wait_d     = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_idx;
          spi_din_d  = req_data[pick_idx*DATA_W +: DATA_W];
          spi_newd_d = 1'b1;
          hold_d     = '0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (hold_q == HW'(NEWD_HOLD - 1)) begin
          state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else begin
          hold_d     = hold_q + 1'b1;
          spi_newd_d = 1'b1;
        end
      end
      WAIT: begin
        if (done_rise) begin
          rsp_data_d = spi_dout;
          ack_d      = NUM_REQ'(1) << grant_id_q;
          state_d    = RESP;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (wait_q == TW'(TIMEOUT_CYC - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          ack_d      = NUM_REQ'(1) << grant_id_q;
          state_d    = RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= GW'(NUM_REQ - 1);
      spi_din_q  <= '0;
      spi_newd_q <= 1'b0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      rsp_data_q <= '0;
      ack_q      <= '0;
      rsp_err_q  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      spi_din_q  <= spi_din_d;
      spi_newd_q <= spi_newd_d;
      hold_q     <= hold_d;
      done_q     <= spi_done;
      rsp_data_q <= rsp_data_d;
      ack_q      <= ack_d;
      rsp_err_q  <= rsp_err_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wait_q     <= wait_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign spi_newd = spi_newd_q;
  assign spi_din  = spi_din_q;

endmodule
